// File: rtl/node_port_pkg.sv
// Shared NoC definitions for the node-side router port: packet layout,
// serialization width and the TX/RX state encodings.
package node_port_pkg;

   localparam int unsigned PKT_BYTES = 4;
   localparam int unsigned PKT_W     = PKT_BYTES * 8;

   typedef struct packed {
      logic [3:0]  src;
      logic [3:0]  dest;
      logic [23:0] data;
   } pkt_t;

   typedef enum logic [2:0] {
      StIdle,
      StB0,
      StB1,
      StB2,
      StB3,
      StGap
   } tx_state_e;

   typedef enum logic [2:0] {
      StRIdle,
      StR1,
      StR2,
      StR3,
      StRFull
   } rx_state_e;

   // Saturating 16-bit increment for the statistics counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/node_tx_fifo.sv
// Packet FIFO for the TX path. Pointers wrap modulo DEPTH and the occupancy
// is kept in its own counter so full/empty need no pointer comparison.
// Writes while full and reads while empty are ignored.
module node_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_wr, do_rd;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];
   assign do_wr = we & ~full;
   assign do_rd = re & ~empty;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
         else if (do_rd && !do_wr) count_q <= count_q - CW'(1);
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (do_wr) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/node_port.sv
// Node-side endpoint of a NoC router link. TX buffers whole packets and
// serializes each into a 4-byte put/payload burst once the router reports
// free; RX reassembles 4-byte bursts into packets and throttles the router
// through free_out. Define NODE_PORT_STATS_EN to add saturating packet
// counters tx_pkt_count / rx_pkt_count.
module node_port
   import node_port_pkg::*;
#(
   parameter int unsigned TXQ_DEPTH  = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] pkt_in,
   input  logic        pkt_in_valid,
   output logic        pkt_in_ready,
   input  logic        free_in,
   output logic        put_out,
   output logic [7:0]  payload_out,
   input  logic        put_in,
   input  logic [7:0]  payload_in,
   output logic        free_out,
   output logic [31:0] pkt_out,
   output logic        pkt_out_valid,
   input  logic        pkt_out_ready,
   output logic        rx_overrun
`ifdef NODE_PORT_STATS_EN
   ,
   output logic [15:0] tx_pkt_count,
   output logic [15:0] rx_pkt_count
`endif
);

   localparam int unsigned CW    = $clog2(TXQ_DEPTH + 1);
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   // ---------------------------------------------------------------- TX
   logic [PKT_W-1:0] fifo_rdata;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             unused_fifo_count;
   pkt_t             head;

   tx_state_e        tx_state_q, tx_state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [31:0]      shift_q, shift_d;
   logic             put_q, put_d;
   logic [7:0]       payload_q, payload_d;
   logic             tx_pop;

   node_tx_fifo #(
      .DEPTH (TXQ_DEPTH),
      .WIDTH (PKT_W)
   ) u_tx_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (pkt_in_valid),
      .wdata   (pkt_in),
      .re      (tx_pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign unused_fifo_count = ^fifo_count;
   assign head              = fifo_rdata;
   assign pkt_in_ready      = ~fifo_full;
   assign put_out           = put_q;
   assign payload_out       = payload_q;

   // TX next state: pop on launch, shift one byte per burst cycle, then gap.
   always_comb begin
      tx_state_d = tx_state_q;
      gap_d      = gap_q;
      shift_d    = shift_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         StIdle: begin
            if (!fifo_empty && free_in) begin
               tx_pop     = 1'b1;
               shift_d    = {head.src, head.dest, head.data};
               tx_state_d = StB0;
            end
         end
         StB0: begin
            shift_d    = {shift_q[23:0], 8'h00};
            tx_state_d = StB1;
         end
         StB1: begin
            shift_d    = {shift_q[23:0], 8'h00};
            tx_state_d = StB2;
         end
         StB2: begin
            shift_d    = {shift_q[23:0], 8'h00};
            tx_state_d = StB3;
         end
         StB3: begin
            gap_d      = '0;
            tx_state_d = StGap;
         end
         StGap: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) tx_state_d = StIdle;
            else                                 gap_d      = gap_q + GAP_W'(1);
         end
         default: tx_state_d = StIdle;
      endcase
      // Outputs are registered from the next state so byte k shows in state Bk.
      put_d     = tx_state_d inside {StB0, StB1, StB2, StB3};
      payload_d = put_d ? shift_d[31:24] : 8'h00;
   end

   // TX state and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tx_state_q <= StIdle;
         gap_q      <= '0;
         shift_q    <= '0;
         put_q      <= 1'b0;
         payload_q  <= 8'h00;
      end else begin
         tx_state_q <= tx_state_d;
         gap_q      <= gap_d;
         shift_q    <= shift_d;
         put_q      <= put_d;
         payload_q  <= payload_d;
      end
   end

   // ---------------------------------------------------------------- RX
   rx_state_e   rx_state_q, rx_state_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] pkt_out_q, pkt_out_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;
   logic        rx_free;

   assign rx_free       = (rx_state_q == StRIdle) && !valid_q;
   assign free_out      = rx_free;
   assign pkt_out       = pkt_out_q;
   assign pkt_out_valid = valid_q;
   assign rx_overrun    = ovr_q;

   // RX next state: gather bytes, publish on the 4th, drop anything unsolicited.
   always_comb begin
      rx_state_d = rx_state_q;
      asm_d      = asm_q;
      pkt_out_d  = pkt_out_q;
      valid_d    = valid_q;
      ovr_d      = ovr_q;
      unique case (rx_state_q)
         StRIdle: begin
            if (put_in) begin
               if (rx_free) begin
                  asm_d      = {asm_q[15:0], payload_in};
                  rx_state_d = StR1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         StR1: begin
            if (put_in) begin
               asm_d      = {asm_q[15:0], payload_in};
               rx_state_d = StR2;
            end
         end
         StR2: begin
            if (put_in) begin
               asm_d      = {asm_q[15:0], payload_in};
               rx_state_d = StR3;
            end
         end
         StR3: begin
            if (put_in) begin
               pkt_out_d  = {asm_q, payload_in};
               valid_d    = 1'b1;
               rx_state_d = StRFull;
            end
         end
         StRFull: begin
            if (put_in) ovr_d = 1'b1;
            if (pkt_out_ready) begin
               valid_d    = 1'b0;
               rx_state_d = StRIdle;
            end
         end
         default: rx_state_d = StRIdle;
      endcase
   end

   // RX state and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rx_state_q <= StRIdle;
         asm_q      <= '0;
         pkt_out_q  <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         asm_q      <= asm_d;
         pkt_out_q  <= pkt_out_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

`ifdef NODE_PORT_STATS_EN
   logic [15:0] tx_cnt_q, rx_cnt_q;

   // Packet counters: TX counts on the last burst byte, RX on packet completion.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_state_q == StB3)                 tx_cnt_q <= sat_inc16(tx_cnt_q);
         if ((rx_state_q == StR3) && put_in)     rx_cnt_q <= sat_inc16(rx_cnt_q);
      end
   end

   assign tx_pkt_count = tx_cnt_q;
   assign rx_pkt_count = rx_cnt_q;
`endif

endmodule
